mod_updown_counter: RTL
=======================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX_VAL, default 255, terminal value of the count range 0..MAX_VAL (legal range 1..2^WIDTH-1).
REQ-003 The block SHALL have parameter SATURATE, default 0, where 0 means wrap at the range ends and 1 means hold at the range ends.
REQ-004 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port clr, input, 1 bit, synchronous clear to 0.
REQ-007 The block SHALL have port load, input, 1 bit, synchronous load of load_val.
REQ-008 The block SHALL have port load_val, input, WIDTH bits, value to load.
REQ-009 The block SHALL have port en, input, 1 bit, count enable.
REQ-010 The block SHALL have port up_dn, input, 1 bit, direction (1 = up, 0 = down).
REQ-011 The block SHALL have port count, output, WIDTH bits, registered count value.
REQ-012 The block SHALL have port tc, output, 1 bit, combinational terminal count.
REQ-013 The block SHALL have port ovf, output, 1 bit, registered one-cycle wrap or saturation-block pulse.

Function
REQ-014 All state SHALL update on the rising edge of clk only, except for reset.
REQ-015 Priority per cycle SHALL be reset > clr > load > en; lower-priority requests in the same cycle SHALL be ignored.
REQ-016 clr=1 SHALL set count to 0 on the next edge and SHALL force ovf=0.
REQ-017 load=1 SHALL set count to load_val, clamped to MAX_VAL when load_val > MAX_VAL, with ovf=0.
REQ-018 en=1 with up_dn=1 SHALL give count+1 when count < MAX_VAL.
REQ-019 en=1 with up_dn=0 SHALL give count-1 when count > 0.
REQ-020 Up step at count==MAX_VAL: SATURATE=0 SHALL give count 0; SATURATE=1 SHALL hold MAX_VAL; both SHALL assert ovf=1 for the following cycle.
REQ-021 Down step at count==0: SATURATE=0 SHALL give count MAX_VAL; SATURATE=1 SHALL hold 0; both SHALL assert ovf=1 for the following cycle.
REQ-022 en=0 with no clr or load SHALL hold count and SHALL give ovf=0.
REQ-023 ovf SHALL be high for exactly one cycle per qualifying step; consecutive blocked steps in SATURATE=1 SHALL keep ovf high in each following cycle.
REQ-024 tc SHALL be 1 when (up_dn=1 and count==MAX_VAL) or (up_dn=0 and count==0), independent of en.
REQ-025 Count arithmetic SHALL be WIDTH bits wide, and count SHALL never exceed MAX_VAL after any edge.
REQ-026 A direction change SHALL take effect on the very next enabled edge, with no dead cycle.

Reset
REQ-027 reset=1 SHALL asynchronously force count=0 and ovf=0, regardless of clk.
REQ-028 reset asserted mid-count SHALL discard the in-progress value; the first enabled edge after deassertion SHALL apply normal rules from count=0.
REQ-029 reset deassertion SHALL be synchronised externally; the block SHALL not require more than one cycle of reset.

Verification
REQ-030 WIDTH=4, MAX_VAL=9, SATURATE=0, up_dn=1, en=1 for 12 cycles from reset -> count 1..9, 0, 1, 2; ovf pulses only in the cycle after 9->0; tc=1 only while count=9.
REQ-031 Same config, up_dn=0, from reset -> count 9, 8, ...; ovf pulses only in the cycle after 0->9; tc=1 at count=0.
REQ-032 SATURATE=1, MAX_VAL=9, count=9, up 3 cycles -> count stays 9; ovf high for 3 consecutive cycles; then down 1 cycle -> count 8 and ovf=0.
REQ-033 load=1 with load_val=13 (MAX_VAL=9) -> count=9; then load=1 and clr=1 in the same cycle -> count=0; then load=1 with en=1 and load_val=5 -> count=5, not 6.
REQ-034 Count reaches 7, then reset pulses high between clock edges -> count=0 immediately with ovf=0; after release, en=1 up -> count 1.
REQ-035 WIDTH=8 with defaults, up_dn toggled every cycle with en=1 from 0 -> count 0->255 (wrap, ovf pulse)->0 (wrap, ovf pulse), confirming immediate direction changes.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with clear/load, combinational terminal count and a
// registered one-cycle pulse on every wrap or saturation-blocked step.
module mod_updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_d, count_q;
  logic             ovf_d, ovf_q;
  logic             at_top, at_bot;

  // >= rather than == so an out-of-range value can never run away upward
  assign at_top = (count_q >= MAX_C);
  assign at_bot = (count_q == '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? MAX_C : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_bot) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? '0 : MAX_C;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign tc    = up_dn ? (count_q == MAX_C) : at_bot;

endmodule
